// File: rtl/cga_vram_sequencer.sv
// cga_vram_sequencer: character clock sequencer, video fetch strobes and CPU/video VRAM arbitration
module cga_vram_sequencer #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hres_mode,
    input  logic              display_enable,
    input  logic [ADDR_W-2:0] video_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata,
    output logic [4:0]        clk_seq,
    output logic              vram_read_char,
    output logic              vram_read_att,
    output logic              charrom_read,
    output logic              disp_pipeline
);
    typedef enum logic [1:0] {IDLE, DATA, DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  seq_q, phase;
    logic [7:0]  rdata_q, rdata_d;
    logic        f_q, char_q, att_q, rom_q, disp_q;
    logic        slot0, slot1, accept;
    // In high-res mode the sequence folds onto 16 cycles so a slot occurs at 0 and 16
    assign phase  = {seq_q[4] & ~hres_mode, seq_q[3:0]};
    assign slot0  = (phase == 5'd0) && display_enable;
    assign slot1  = (phase == 5'd1) && f_q;
    assign accept = (state_q == IDLE) && cpu_req && !(slot0 || slot1);
    always_comb begin
        state_d = (state_q == DATA) ? DONE : (state_q == DONE) ? IDLE : accept ? DATA : IDLE;
        rdata_d = (state_q == DATA && !cpu_we) ? vram_rdata : rdata_q;
    end
    assign vram_addr      = slot0 ? {video_addr, 1'b0} : slot1 ? {video_addr, 1'b1} : cpu_addr;
    assign vram_we        = accept && cpu_we;
    assign vram_wdata     = cpu_wdata;
    assign cpu_ack        = (state_q == DONE);
    assign cpu_rdata      = rdata_q;
    assign clk_seq        = seq_q;
    assign vram_read_char = char_q;
    assign vram_read_att  = att_q;
    assign charrom_read   = rom_q;
    assign disp_pipeline  = disp_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q   <= '0;
            state_q <= IDLE;
            rdata_q <= '0;
            f_q     <= 1'b0;
            char_q  <= 1'b0;
            att_q   <= 1'b0;
            rom_q   <= 1'b0;
            disp_q  <= 1'b0;
        end else begin
            seq_q   <= seq_q + 5'd1;
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (phase == 5'd0) f_q <= display_enable;
            char_q  <= slot0;
            att_q   <= slot1;
            rom_q   <= slot1;
            disp_q  <= (phase == 5'd2);
        end
    end
endmodule
